// File: rtl/fir_out_quant.sv
// -----------------------------------------------------------------------------
// fir_out_quant
// Output stage of a FIR filter. It rounds (half up) and saturates a 2*DWIDTH
// accumulator sample down to DWIDTH bits, keeps only every DECIM-th accepted
// sample, and buffers the kept samples in a 2-entry skid FIFO with
// valid/ready handshakes on both sides.
//
// Parameters
//   DWIDTH : output sample width; the input is 2*DWIDTH wide (Q2.30 -> Q1.15)
//   DECIM  : decimation factor, 1..16 (1 = pure quantiser)
//
// Ports
//   clk      : clock, rising edge
//   rstn     : asynchronous active-low reset
//   i_data   : signed accumulator sample
//   i_valid  : i_data valid
//   o_ready  : block accepts i_data (registered, no path from i_ready)
//   i_clear  : synchronous flush of the phase counter and the FIFO
//   o_data   : signed quantised sample (FIFO head)
//   o_valid  : o_data valid
//   i_ready  : downstream accepts o_data
//   o_sat_cnt: (only with FIR_QUANT_SAT_CNT_EN defined) sticky count of
//              forwarded samples that were clipped; cleared by i_clear
//
// Optional feature macro: FIR_QUANT_SAT_CNT_EN
// -----------------------------------------------------------------------------
module fir_out_quant #(
  parameter int DWIDTH = 16,
  parameter int DECIM  = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [2*DWIDTH-1:0]   i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_clear,
  output logic [DWIDTH-1:0]     o_data,
  output logic                  o_valid,
  input  logic                  i_ready
`ifdef FIR_QUANT_SAT_CNT_EN
  ,
  output logic [15:0]           o_sat_cnt
`endif
);

  localparam logic [3:0] PHASE_LAST = 4'(DECIM - 1);

  // Rounding constant 2^(DWIDTH-2) in the 2*DWIDTH+1 bit sum width.
  localparam logic signed [2*DWIDTH:0] RND_C =
    {{(DWIDTH+2){1'b0}}, 1'b1, {(DWIDTH-2){1'b0}}};
  localparam logic signed [2*DWIDTH:0] QMAX_C =
    {{(DWIDTH+2){1'b0}}, {(DWIDTH-1){1'b1}}};
  localparam logic signed [2*DWIDTH:0] QMIN_C =
    {{(DWIDTH+2){1'b1}}, {(DWIDTH-1){1'b0}}};

  // Round half up: add half an output LSB, then arithmetic shift.
  function automatic logic signed [2*DWIDTH:0] round_q(input logic [2*DWIDTH-1:0] din);
    logic signed [2*DWIDTH:0] sum;
    sum = $signed({din[2*DWIDTH-1], din}) + RND_C;
    return sum >>> (DWIDTH - 1);
  endfunction

  // Clip the rounded value into the signed DWIDTH range.
  function automatic logic [DWIDTH-1:0] sat_q(input logic [2*DWIDTH-1:0] din);
    logic signed [2*DWIDTH:0] q;
    q = round_q(din);
    if (q > QMAX_C) begin
      return {1'b0, {(DWIDTH-1){1'b1}}};
    end else if (q < QMIN_C) begin
      return {1'b1, {(DWIDTH-1){1'b0}}};
    end else begin
      return q[DWIDTH-1:0];
    end
  endfunction

  logic [1:0]        count_r, count_nx_s;
  logic [3:0]        phase_r, phase_nx_s;
  logic [DWIDTH-1:0] head_r, head_nx_s;
  logic [DWIDTH-1:0] tail_r, tail_nx_s;
  logic              valid_r, ready_r;
  logic              accept_s, pop_s, fwd_s;
  logic [DWIDTH-1:0] quant_s;

  assign o_data  = head_r;
  assign o_valid = valid_r;
  assign o_ready = ready_r;

  // Next-state logic for phase counter and the 2-entry FIFO (head/tail).
  always_comb begin
    accept_s   = i_valid & ready_r;
    pop_s      = valid_r & i_ready;
    fwd_s      = accept_s & (phase_r == 4'd0);
    quant_s    = sat_q(i_data);
    count_nx_s = count_r;
    phase_nx_s = phase_r;
    head_nx_s  = head_r;
    tail_nx_s  = tail_r;
    if (i_clear) begin
      // Flush wins over any push or pop in the same cycle.
      count_nx_s = 2'd0;
      phase_nx_s = 4'd0;
    end else begin
      if (accept_s) begin
        if (phase_r == PHASE_LAST) begin
          phase_nx_s = 4'd0;
        end else begin
          phase_nx_s = phase_r + 4'd1;
        end
      end else begin
        phase_nx_s = phase_r;
      end
      case ({fwd_s, pop_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            head_nx_s  = quant_s;
            count_nx_s = 2'd1;
          end else if (count_r == 2'd1) begin
            tail_nx_s  = quant_s;
            count_nx_s = 2'd2;
          end else begin
            count_nx_s = count_r;
          end
        end
        2'b01: begin
          if (count_r == 2'd2) begin
            head_nx_s  = tail_r;
            count_nx_s = 2'd1;
          end else if (count_r == 2'd1) begin
            count_nx_s = 2'd0;
          end else begin
            count_nx_s = count_r;
          end
        end
        2'b11: begin
          // Push implies count < 2 and pop implies count > 0, so count is 1:
          // the new sample replaces the head and the level stays at 1.
          if (count_r == 2'd1) begin
            head_nx_s = quant_s;
          end else begin
            head_nx_s = head_r;
          end
        end
        default: begin
          count_nx_s = count_r;
        end
      endcase
    end
  end

  // State registers; valid/ready are precomputed from the next count so the
  // handshake outputs come straight from flops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_r <= 2'd0;
      phase_r <= 4'd0;
      head_r  <= {DWIDTH{1'b0}};
      tail_r  <= {DWIDTH{1'b0}};
      valid_r <= 1'b0;
      ready_r <= 1'b0;
    end else begin
      count_r <= count_nx_s;
      phase_r <= phase_nx_s;
      head_r  <= head_nx_s;
      tail_r  <= tail_nx_s;
      valid_r <= (count_nx_s != 2'd0);
      ready_r <= (count_nx_s < 2'd2);
    end
  end

`ifdef FIR_QUANT_SAT_CNT_EN
  logic [15:0] sat_cnt_r;
  logic        clip_s;

  // A forwarded sample was clipped when the rounded value is out of range.
  function automatic logic is_clip(input logic [2*DWIDTH-1:0] din);
    logic signed [2*DWIDTH:0] q;
    q = round_q(din);
    return (q > QMAX_C) || (q < QMIN_C);
  endfunction

  assign clip_s    = is_clip(i_data);
  assign o_sat_cnt = sat_cnt_r;

  // Sticky saturation counter for forwarded samples.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sat_cnt_r <= 16'd0;
    end else if (i_clear) begin
      sat_cnt_r <= 16'd0;
    end else if (fwd_s && clip_s && (sat_cnt_r != 16'hFFFF)) begin
      sat_cnt_r <= sat_cnt_r + 16'd1;
    end else begin
      sat_cnt_r <= sat_cnt_r;
    end
  end
`endif

endmodule
